// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter slice.
// Contents:
//   state_t  - arbiter FSM states (IDLE, GRANT, ACK), 2-bit encoding
//   onehot() - builds a one-hot vector (up to MAX_REQ bits) from an index
package shared_reg_pkg;

  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Callers truncate the result to their own requester count; indices at or
  // beyond n produce an all-zero vector rather than a stray bit.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] id,
                                                input int n);
    logic [MAX_REQ-1:0] result;
    result = '0;
    if (int'(id) < n) result[id] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesting datapath blocks and the shared-register arbiter.
// Signals:
//   req     - per-requester write request (level)
//   wdata   - packed write data, slice i = wdata[i*WIDTH +: WIDTH]
//   clr     - synchronous clear pulse
//   gnt     - one-hot registered grant
//   ack     - one-hot registered completion pulse
//   q       - shared register contents
//   q_valid - q holds requester data since last reset/clear
//   owner   - index of the last requester that wrote q
//   busy    - arbiter is mid-transaction
// Modports: master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic                     clr;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;
  logic [ID_W-1:0]          owner;
  logic                     busy;

  modport master (
    output req, wdata, clr,
    input  gnt, ack, q, q_valid, owner, busy
  );

  modport slave (
    input  req, wdata, clr,
    output gnt, ack, q, q_valid, owner, busy
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_priority_pick.sv
// Round-robin winner selection, purely combinational.
// Ports:
//   req     - request vector
//   rr_last - index of the most recent winner (lowest priority next)
//   any     - at least one request is pending
//   win_id  - first requester found scanning rr_last+1, rr_last+2, ... mod NUM_REQ
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_last,
  output logic               any,
  output logic [ID_W-1:0]    win_id
);

  logic [NUM_REQ-1:0] rotated;
  int                 first;

  // Rotate so that position 0 is the requester just after rr_last, take the
  // lowest set bit, then map that position back to a real requester index.
  // The nested compare loop keeps every bit select a constant index.
  always_comb begin
    rotated = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((int'(rr_last) + 1 + j) % NUM_REQ) == i) rotated[j] = req[i];
      end
    end

    first = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rotated[j]) first = j;
    end

    any    = |rotated;
    win_id = ID_W'((int'(rr_last) + 1 + first) % NUM_REQ);
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// Each write is a fixed 3-cycle transaction: IDLE (arbitrate) -> GRANT
// (register loads the winner's data) -> ACK (completion pulse, priority
// rotates). A clear pulse zeroes the register, but only while IDLE.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - shared_reg_arbiter_if slave modport (req/wdata/clr in,
//           gnt/ack/q/q_valid/owner/busy out)
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input logic                 clock,
  input logic                 reset,
  shared_reg_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_last_q, rr_last_d;
  logic [ID_W-1:0]    win_q, win_d;
  logic               busy_q;

  logic               pick_any;
  logic [ID_W-1:0]    pick_id;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req),
    .rr_last (rr_last_q),
    .any     (pick_any),
    .win_id  (pick_id)
  );

  // rr_last starts at the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      rr_last_q <= ID_W'(NUM_REQ - 1);
      win_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      win_q     <= win_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // gnt and ack default to zero so each is a single-cycle pulse. Clear takes
  // precedence over arbitration in IDLE, and req/clr changes during
  // GRANT/ACK never disturb a transaction already in flight.
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    ack_d     = '0;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    win_d     = win_q;

    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          q_d       = '0;
          q_valid_d = 1'b0;
        end else if (pick_any) begin
          win_d   = pick_id;
          gnt_d   = NUM_REQ'(onehot(MAX_ID_W'(pick_id), NUM_REQ));
          state_d = GRANT;
        end
      end

      GRANT: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (win_q == ID_W'(i)) q_d = bus.wdata[i*WIDTH +: WIDTH];
        end
        q_valid_d = 1'b1;
        owner_d   = win_q;
        ack_d     = NUM_REQ'(onehot(MAX_ID_W'(win_q), NUM_REQ));
        state_d   = ACK;
      end

      ACK: begin
        rr_last_d = win_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;

endmodule
